mips_cpu_mem_arbiter: RTL and testbench

Sequencer and arbiter sharing the CPU's single Avalon-MM memory master port between the instruction-fetch path and the load/store datapath. Accepts level-held requests from both, grants one at a time with round-robin fairness, and drives word-aligned `address`, `read`, `write`, `byteenable` and `writedata` until the slave releases `waitrequest`. Read data is captured into a per-port register and returned with a one-cycle acknowledge pulse. Sits between the fetch/decode control, the load/store unit and the top-level bus pins.

---
 rtl/mips_cpu_mem_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_mem_arbiter.sv
// Round-robin sequencer sharing one Avalon-MM master between instruction fetch and load/store.
// Optional waitrequest timeout with sticky err flag: define MEM_ARB_TIMEOUT_EN.
module mips_cpu_mem_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        reset,
   // fetch port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   // load/store port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_byteenable,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   // Avalon-MM master
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [3:0]  byteenable,
   output logic [31:0] writedata,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   // status
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic PORT_FETCH = 1'b0;
   localparam logic PORT_DATA  = 1'b1;

   state_t      r_state,   w_state_nx;
   logic        r_port,    w_port_nx;
   logic        r_last,    w_last_nx;
   logic [29:0] r_addr,    w_addr_nx;
   logic        r_we,      w_we_nx;
   logic [3:0]  r_be,      w_be_nx;
   logic [31:0] r_wdata,   w_wdata_nx;
   logic        r_read,    w_read_nx;
   logic        r_write,   w_write_nx;
   logic        r_i_ack,   w_i_ack_nx;
   logic        r_d_ack,   w_d_ack_nx;
   logic [31:0] r_i_rdata, w_i_rdata_nx;
   logic [31:0] r_d_rdata, w_d_rdata_nx;

   logic        w_i_cand;
   logic        w_d_cand;
   logic        w_grant_d;
   logic [31:0] w_capture;
   logic        w_unused;

`ifdef MEM_ARB_TIMEOUT_EN
   logic [15:0] r_cnt,   w_cnt_nx;
   logic        r_abort, w_abort_nx;
   logic        r_err,   w_err_nx;
   logic [16:0] w_cnt_inc;

   assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
   // An aborted read returns zero rather than whatever the stalled slave drives.
   assign w_capture = r_abort ? 32'h0000_0000 : readdata;
   assign err       = r_err;
`else
   logic [15:0] w_unused_timeout;

   assign w_unused_timeout = TIMEOUT_CYCLES[15:0];
   assign w_capture        = readdata;
   assign err              = 1'b0;
`endif

   // A port whose ack is showing this cycle has just finished and may not win again yet.
   assign w_i_cand  = i_req & ~r_i_ack;
   assign w_d_cand  = d_req & ~r_d_ack;
   assign w_grant_d = w_d_cand & (~w_i_cand | (r_last == PORT_FETCH));

   assign w_unused  = ^{i_addr[1:0], d_addr[1:0]};

   always_comb begin
      // NOTE: every next value defaults to its current register first, so no path leaves
      // a variable unassigned and no latch can be inferred.
      w_state_nx   = r_state;
      w_port_nx    = r_port;
      w_last_nx    = r_last;
      w_addr_nx    = r_addr;
      w_we_nx      = r_we;
      w_be_nx      = r_be;
      w_wdata_nx   = r_wdata;
      w_read_nx    = r_read;
      w_write_nx   = r_write;
      w_i_ack_nx   = 1'b0;
      w_d_ack_nx   = 1'b0;
      w_i_rdata_nx = r_i_rdata;
      w_d_rdata_nx = r_d_rdata;
`ifdef MEM_ARB_TIMEOUT_EN
      w_cnt_nx     = r_cnt;
      w_abort_nx   = r_abort;
      w_err_nx     = r_err;
`endif

      case (r_state)
         S_IDLE: begin
            if (w_grant_d) begin
               w_port_nx  = PORT_DATA;
               w_last_nx  = PORT_DATA;
               w_addr_nx  = d_addr[31:2];
               w_we_nx    = d_we;
               w_be_nx    = d_byteenable;
               w_wdata_nx = d_wdata;
               w_read_nx  = ~d_we;
               w_write_nx = d_we;
               w_state_nx = S_BUS;
`ifdef MEM_ARB_TIMEOUT_EN
               w_cnt_nx   = 16'd0;
               w_abort_nx = 1'b0;
`endif
            end else if (w_i_cand) begin
               w_port_nx  = PORT_FETCH;
               w_last_nx  = PORT_FETCH;
               w_addr_nx  = i_addr[31:2];
               w_we_nx    = 1'b0;
               w_be_nx    = 4'b1111;
               w_wdata_nx = 32'h0000_0000;
               w_read_nx  = 1'b1;
               w_write_nx = 1'b0;
               w_state_nx = S_BUS;
`ifdef MEM_ARB_TIMEOUT_EN
               w_cnt_nx   = 16'd0;
               w_abort_nx = 1'b0;
`endif
            end
         end

         S_BUS: begin
            if (!waitrequest) begin
               w_read_nx  = 1'b0;
               w_write_nx = 1'b0;
               w_state_nx = S_RESP;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (w_cnt_inc == 17'(TIMEOUT_CYCLES)) begin
               w_read_nx  = 1'b0;
               w_write_nx = 1'b0;
               w_abort_nx = 1'b1;
               w_err_nx   = 1'b1;
               w_state_nx = S_RESP;
            end else begin
               w_cnt_nx   = w_cnt_inc[15:0];
            end
`endif
         end

         S_RESP: begin
            w_state_nx = S_IDLE;
            if (r_port == PORT_DATA) begin
               w_d_ack_nx = 1'b1;
               if (!r_we) begin
                  w_d_rdata_nx = w_capture;
               end
            end else begin
               w_i_ack_nx   = 1'b1;
               w_i_rdata_nx = w_capture;
            end
         end

         default: begin
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples the
   // pre-edge values computed above, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_port    <= PORT_FETCH;
         r_last    <= PORT_FETCH;
         r_addr    <= '0;
         r_we      <= 1'b0;
         r_be      <= '0;
         r_wdata   <= '0;
         r_read    <= 1'b0;
         r_write   <= 1'b0;
         r_i_ack   <= 1'b0;
         r_d_ack   <= 1'b0;
         r_i_rdata <= '0;
         r_d_rdata <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt     <= '0;
         r_abort   <= 1'b0;
         r_err     <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nx;
         r_port    <= w_port_nx;
         r_last    <= w_last_nx;
         r_addr    <= w_addr_nx;
         r_we      <= w_we_nx;
         r_be      <= w_be_nx;
         r_wdata   <= w_wdata_nx;
         r_read    <= w_read_nx;
         r_write   <= w_write_nx;
         r_i_ack   <= w_i_ack_nx;
         r_d_ack   <= w_d_ack_nx;
         r_i_rdata <= w_i_rdata_nx;
         r_d_rdata <= w_d_rdata_nx;
`ifdef MEM_ARB_TIMEOUT_EN
         r_cnt     <= w_cnt_nx;
         r_abort   <= w_abort_nx;
         r_err     <= w_err_nx;
`endif
      end
   end

   assign address    = {r_addr, 2'b00};
   assign read       = r_read;
   assign write      = r_write;
   assign byteenable = r_be;
   assign writedata  = r_wdata;
   assign i_ack      = r_i_ack;
   assign d_ack      = r_d_ack;
   assign i_rdata    = r_i_rdata;
   assign d_rdata    = r_d_rdata;
   assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Self-checking bench for mips_cpu_mem_arbiter: directed cases plus randomized single
// transactions compared against a transaction-level model of latency, bus fields and read data.
module tb_mips_cpu_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ack;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [3:0]  d_byteenable;
   logic [31:0] d_wdata;
   logic        d_ack;
   logic [31:0] d_rdata;
   logic [31:0] address;
   logic        read;
   logic        write;
   logic [3:0]  byteenable;
   logic [31:0] writedata;
   logic        waitrequest;
   logic [31:0] readdata;
   logic        busy;
   logic        err;

   int total = 0;
   int bad   = 0;

   // model of the two captured read words
   logic [31:0] exp_i_rdata;
   logic [31:0] exp_d_rdata;

   mips_cpu_mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_ack        (i_ack),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_byteenable (d_byteenable),
      .d_wdata      (d_wdata),
      .d_ack        (d_ack),
      .d_rdata      (d_rdata),
      .address      (address),
      .read         (read),
      .write        (write),
      .byteenable   (byteenable),
      .writedata    (writedata),
      .waitrequest  (waitrequest),
      .readdata     (readdata),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      exp_i_rdata = 32'h0;
      exp_d_rdata = 32'h0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_read"},    read,       0);
      check({tag, "_write"},   write,      0);
      check({tag, "_address"}, address,    0);
      check({tag, "_be"},      byteenable, 0);
      check({tag, "_wdata"},   writedata,  0);
      check({tag, "_i_ack"},   i_ack,      0);
      check({tag, "_d_ack"},   d_ack,      0);
      check({tag, "_i_rdata"}, i_rdata,    0);
      check({tag, "_d_rdata"}, d_rdata,    0);
      check({tag, "_busy"},    busy,       0);
      check({tag, "_err"},     err,        0);
   endtask

   // One isolated transaction with 'stalls' waitrequest-high edges. Expected behaviour:
   // strobe for stalls+1 cycles, ack on edge stalls+2 counted from the grant edge.
   task automatic run_txn(input bit is_data, input logic [31:0] addr, input bit we,
                          input logic [3:0] be, input logic [31:0] wd, input logic [31:0] rd,
                          input int stalls, input string tag);
      logic [31:0] e_addr;
      logic        e_rd;
      logic        e_wr;
      logic [3:0]  e_be;
      int          strobe_n;
      int          ack_at;
      bit          got;
      e_addr = {addr[31:2], 2'b00};
      e_rd   = !is_data || !we;
      e_wr   = is_data && we;
      e_be   = is_data ? be : 4'b1111;
      if (is_data) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_byteenable = be; d_wdata = wd;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      readdata    = rd;
      waitrequest = 1'b1;
      strobe_n    = 0;
      ack_at      = -1;
      got         = 1'b0;
      for (int c = 0; c < 40 && !got; c++) begin
         tick();
         if (c == 0) begin
            // requester inputs changing after grant must not reach the bus
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
            d_byteenable = 4'($urandom); d_we = 1'($urandom);
         end
         check({tag, "_rw_excl"}, read & write, 0);
         if (read || write) begin
            strobe_n++;
            check({tag, "_address"}, address,    e_addr);
            check({tag, "_be"},      byteenable, e_be);
            check({tag, "_read"},    read,       e_rd);
            check({tag, "_write"},   write,      e_wr);
            check({tag, "_busy"},    busy,       1);
            if (e_wr) check({tag, "_wdata"}, writedata, wd);
         end
         waitrequest = (c + 1 <= stalls);
         if (i_ack || d_ack) begin
            got    = 1'b1;
            ack_at = c;
            check({tag, "_ack_port"}, d_ack, is_data);
            check({tag, "_ack_other"}, is_data ? i_ack : d_ack, 0);
         end
      end
      check({tag, "_ack_seen"}, got, 1);
      check({tag, "_latency"}, ack_at, stalls + 2);
      check({tag, "_strobe_cycles"}, strobe_n, stalls + 1);
      if (!e_wr) begin
         if (is_data) exp_d_rdata = rd;
         else         exp_i_rdata = rd;
      end
      check({tag, "_i_rdata"}, i_rdata, exp_i_rdata);
      check({tag, "_d_rdata"}, d_rdata, exp_d_rdata);
      check({tag, "_busy_ack"}, busy, 0);
      i_req = 1'b0;
      d_req = 1'b0;
      readdata = $urandom;
      waitrequest = 1'b0;
      tick();
      check({tag, "_ack_clear"}, i_ack | d_ack, 0);
      check({tag, "_idle"}, busy, 0);
      check({tag, "_err"}, err, 0);
   endtask

   initial begin
      logic [31:0] rd;
      bit          exp_i;
      bit          exp_d;
      int          k;

      reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_byteenable = '0; d_wdata = '0; waitrequest = 1'b0; readdata = '0;

      // reset state
      do_reset();
      check_all_zero("reset");

      // single fetch and a stalled store
      run_txn(1'b0, 32'hBFC0_0003, 1'b0, 4'hF, 32'h0, 32'h8C01_0004, 0, "fetch1");
      run_txn(1'b1, 32'h1000_0009, 1'b1, 4'b0100, 32'h00AB_0000, $urandom, 4, "store");
      run_txn(1'b1, 32'h2000_0012, 1'b0, 4'b0011, 32'h0, 32'hCAFE_F00D, 1, "load");

      // contention: after reset data wins first, then strict alternation every 3 cycles
      do_reset();
      rd = 32'h1234_5678;
      i_req = 1'b1; i_addr = 32'h0040_0000;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1000_0000; d_byteenable = 4'hF;
      d_wdata = 32'hDEAD_BEEF; waitrequest = 1'b0; readdata = rd;
      for (int c = 0; c < 24; c++) begin
         tick();
         k = c - 2;
         exp_d = (c >= 2) && (k % 3 == 0) && ((k / 3) % 2 == 0);
         exp_i = (c >= 2) && (k % 3 == 0) && ((k / 3) % 2 == 1);
         check("cont_rw_excl", read & write, 0);
         check("cont_d_ack", d_ack, exp_d);
         check("cont_i_ack", i_ack, exp_i);
      end
      i_req = 1'b0;
      d_req = 1'b0;
      exp_i_rdata = rd;
      tick();
      tick();
      check("cont_i_rdata", i_rdata, exp_i_rdata);
      check("cont_d_rdata", d_rdata, exp_d_rdata);
      check("cont_idle", busy, 0);

      // reset during the second stall cycle of a fetch
      i_req = 1'b1; i_addr = 32'h0000_0100; waitrequest = 1'b1;
      tick();
      check("rst_bus_read", read, 1);
      tick();
      reset = 1'b1;
      tick();
      check_all_zero("rst_mid");
      reset = 1'b0;
      i_req = 1'b0;
      waitrequest = 1'b0;
      exp_i_rdata = 32'h0;
      exp_d_rdata = 32'h0;
      tick();
      check("rst_no_ack", i_ack | d_ack, 0);
      check("rst_idle", busy, 0);
      run_txn(1'b0, 32'h0000_0104, 1'b0, 4'hF, 32'h0, 32'h2402_0001, 2, "post_rst");

      // randomized isolated transactions
      for (int n = 0; n < 30; n++) begin
         run_txn(1'($urandom), $urandom, 1'($urandom), 4'($urandom), $urandom, $urandom,
                 int'($urandom_range(0, 3)), "rand");
      end

`ifdef MEM_ARB_TIMEOUT_EN
      begin
         int  strobe_n;
         int  ack_at;
         bit  got;
         d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000_0000; d_byteenable = 4'hF;
         waitrequest = 1'b1; readdata = 32'hFFFF_FFFF;
         strobe_n = 0; ack_at = -1; got = 1'b0;
         for (int c = 0; c < 30 && !got; c++) begin
            tick();
            if (read) strobe_n++;
            if (d_ack) begin got = 1'b1; ack_at = c; end
         end
         check("to_ack_seen", got, 1);
         check("to_strobe_cycles", strobe_n, 8);
         check("to_latency", ack_at, 9);
         check("to_d_rdata", d_rdata, 0);
         check("to_err", err, 1);
         d_req = 1'b0;
         waitrequest = 1'b0;
         tick();
         tick();
         check("to_err_sticky", err, 1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
